// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control path: opcodes, ALU/WB/PC-select codes, FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rv_ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0100;
    localparam logic [3:0] ALU_XOR = 4'b1000;
    localparam logic [3:0] ALU_SRL = 4'b1001;
    localparam logic [3:0] ALU_SLL = 4'b1010;
    localparam logic [3:0] ALU_SRA = 4'b1100;
    localparam logic [3:0] ALU_LUI = 4'b1101;

    localparam logic [1:0] WB_LT  = 2'b00;
    localparam logic [1:0] WB_ALU = 2'b01;
    localparam logic [1:0] WB_MEM = 2'b10;
    localparam logic [1:0] WB_PC4 = 2'b11;

    localparam logic [1:0] PCSRC_PC4  = 2'b00;
    localparam logic [1:0] PCSRC_BR   = 2'b01;
    localparam logic [1:0] PCSRC_JALR = 2'b10;

    localparam logic [1:0] WHB_W = 2'b10;

    typedef enum logic [2:0] {
        FETCH, DECODE, EXEC, MEM, WB, TRAP
    } state_t;

    typedef enum logic [2:0] {
        CL_ALU, CL_LOAD, CL_STORE, CL_BRANCH, CL_JAL, CL_JALR
    } iclass_t;

    typedef struct packed {
        logic [3:0] alu_ctrl;
        logic       alu_src_a;
        logic       alu_src_b;
        logic [1:0] wb_sel;
        logic [1:0] whb;
        logic       su;
        logic       dmem_we;
        iclass_t    iclass;
        logic       illegal;
    } dec_t;

    // SLT/SLTU reuse SUB; the lt flag comes from the ALU compare path.
    function automatic logic [3:0] alu_from_f3(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:         return alt ? ALU_SUB : ALU_ADD;
            3'b001:         return ALU_SLL;
            3'b010, 3'b011: return ALU_SUB;
            3'b100:         return ALU_XOR;
            3'b101:         return alt ? ALU_SRA : ALU_SRL;
            3'b110:         return ALU_OR;
            default:        return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/rv_decoder.sv
// Combinational RV32I decode of the latched IR into control fields, class and illegal flag.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows IR.
module rv_decoder
    import rv_ctrl_pkg::*;
(
    input  logic [31:0] i_ir,
    output dec_t        o_dec
);

    logic [6:0] w_op;
    logic [2:0] w_f3;
    logic [6:0] w_f7;
    logic       w_slt;
    logic       w_unused_ir;

    assign w_op        = i_ir[6:0];
    assign w_f3        = i_ir[14:12];
    assign w_f7        = i_ir[31:25];
    assign w_slt       = (w_f3 == 3'b010) || (w_f3 == 3'b011);
    assign w_unused_ir = ^{i_ir[24:15], i_ir[11:7]};

    always_comb begin
        o_dec.alu_ctrl  = ALU_ADD;
        o_dec.alu_src_a = 1'b0;
        o_dec.alu_src_b = 1'b0;
        o_dec.wb_sel    = WB_ALU;
        o_dec.whb       = WHB_W;
        o_dec.su        = 1'b1;
        o_dec.dmem_we   = 1'b0;
        o_dec.iclass    = CL_ALU;
        o_dec.illegal   = 1'b0;
        case (w_op)
            OP_R: begin
                o_dec.alu_ctrl = alu_from_f3(w_f3, w_f7[5]);
                o_dec.wb_sel   = w_slt ? WB_LT : WB_ALU;
                o_dec.su       = (w_f3 != 3'b011);
                o_dec.illegal  = !((w_f7 == F7_BASE) ||
                                   ((w_f7 == F7_ALT) && ((w_f3 == 3'b000) || (w_f3 == 3'b101))));
            end
            OP_IALU: begin
                // imm[10] only selects SRAI; for ADDI it is just an immediate bit.
                o_dec.alu_ctrl  = alu_from_f3(w_f3, (w_f3 == 3'b101) && w_f7[5]);
                o_dec.alu_src_b = 1'b1;
                o_dec.wb_sel    = w_slt ? WB_LT : WB_ALU;
                o_dec.su        = (w_f3 != 3'b011);
                if (w_f3 == 3'b001) begin
                    o_dec.illegal = (w_f7 != F7_BASE);
                end else if (w_f3 == 3'b101) begin
                    o_dec.illegal = (w_f7 != F7_BASE) && (w_f7 != F7_ALT);
                end
            end
            OP_LOAD: begin
                o_dec.iclass    = CL_LOAD;
                o_dec.alu_src_b = 1'b1;
                o_dec.wb_sel    = WB_MEM;
                o_dec.whb       = w_f3[1:0];
                o_dec.su        = !w_f3[2];
                o_dec.illegal   = (w_f3 == 3'b011) || (w_f3 == 3'b110) || (w_f3 == 3'b111);
            end
            OP_STORE: begin
                o_dec.iclass    = CL_STORE;
                o_dec.alu_src_b = 1'b1;
                o_dec.whb       = w_f3[1:0];
                o_dec.dmem_we   = 1'b1;
                o_dec.illegal   = w_f3[2] || (w_f3[1:0] == 2'b11);
            end
            OP_BRANCH: begin
                o_dec.iclass   = CL_BRANCH;
                o_dec.alu_ctrl = ALU_SUB;
                o_dec.su       = !w_f3[1];
                o_dec.illegal  = (w_f3 == 3'b010) || (w_f3 == 3'b011);
            end
            OP_JAL: begin
                o_dec.iclass    = CL_JAL;
                o_dec.alu_src_a = 1'b1;
                o_dec.alu_src_b = 1'b1;
                o_dec.wb_sel    = WB_PC4;
            end
            OP_JALR: begin
                o_dec.iclass    = CL_JALR;
                o_dec.alu_src_b = 1'b1;
                o_dec.wb_sel    = WB_PC4;
                o_dec.illegal   = (w_f3 != 3'b000);
            end
            OP_LUI: begin
                o_dec.alu_ctrl  = ALU_LUI;
                o_dec.alu_src_b = 1'b1;
            end
            OP_AUIPC: begin
                o_dec.alu_src_a = 1'b1;
                o_dec.alu_src_b = 1'b1;
            end
            default: o_dec.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB with imem/dmem req/ack, timeout and illegal trap.
// Latency: ALU/JAL/JALR 4, load 5, store 4, branch 3 cycles with zero-wait acks.
// Backpressure: requests held until ack; TIMEOUT cycles without ack traps until reset.
module mc_control_unit
    import rv_ctrl_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instr,
    input  logic             imem_ack,
    input  logic             dmem_ack,
    input  logic             br_cond,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       pc_src,
    output logic             reg_write,
    output logic [3:0]       alu_ctrl,
    output logic             alu_src_a,
    output logic             alu_src_b,
    output logic [1:0]       wb_sel,
    output logic [1:0]       whb,
    output logic             su,
    output logic             trap,
    output logic [CNT_W-1:0] retired
);

    localparam int             TO_W    = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    if (TIMEOUT < 1 || XLEN < 32) begin : g_bad_param
        $error("mc_control_unit: TIMEOUT must be >= 1 and XLEN >= 32");
    end

    state_t           r_state;
    state_t           w_next;
    logic [31:0]      r_ir;
    logic [TO_W-1:0]  r_to_cnt;
    logic [CNT_W-1:0] r_retired;
    dec_t             w_dec;
    logic             w_req;
    logic             w_ack;
    logic             w_wait;
    logic             w_to_hit;
    logic             w_retire;
    logic             w_is_store;

    rv_decoder u_dec (
        .i_ir  (r_ir),
        .o_dec (w_dec)
    );

    assign w_is_store = (w_dec.iclass == CL_STORE);
    assign w_req      = (r_state == FETCH) || (r_state == MEM);
    assign w_ack      = (r_state == FETCH) ? imem_ack : dmem_ack;
    assign w_wait     = w_req && !w_ack;
    // An ack in the limit cycle clears w_wait, so it takes priority over the trap.
    assign w_to_hit   = w_wait && (r_to_cnt == TO_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= FETCH;
            r_ir      <= '0;
            r_to_cnt  <= '0;
            r_retired <= '0;
        end else begin
            r_state <= w_next;
            if ((r_state == FETCH) && imem_ack) begin
                r_ir <= instr;
            end
            if (w_next != r_state) begin
                r_to_cnt <= '0;
            end else if (w_wait) begin
                r_to_cnt <= r_to_cnt + TO_W'(1);
            end
            if (w_retire) begin
                r_retired <= r_retired + CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_next   = r_state;
        w_retire = 1'b0;
        case (r_state)
            FETCH: begin
                if (imem_ack) begin
                    w_next = DECODE;
                end else if (w_to_hit) begin
                    w_next = TRAP;
                end
            end
            DECODE: w_next = w_dec.illegal ? TRAP : EXEC;
            EXEC: begin
                case (w_dec.iclass)
                    CL_BRANCH: begin
                        w_next   = FETCH;
                        w_retire = 1'b1;
                    end
                    CL_LOAD, CL_STORE: w_next = MEM;
                    default:           w_next = WB;
                endcase
            end
            MEM: begin
                if (dmem_ack) begin
                    w_next   = w_is_store ? FETCH : WB;
                    w_retire = w_is_store;
                end else if (w_to_hit) begin
                    w_next = TRAP;
                end
            end
            WB: begin
                w_next   = FETCH;
                w_retire = 1'b1;
            end
            default: w_next = TRAP;
        endcase
    end

    // Strobes that complete a handshake (ir_we, store pc_we) are qualified by the ack.
    always_comb begin
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        pc_src    = PCSRC_PC4;
        reg_write = 1'b0;
        alu_ctrl  = ALU_ADD;
        alu_src_a = 1'b0;
        alu_src_b = 1'b0;
        wb_sel    = WB_LT;
        whb       = WHB_W;
        su        = 1'b1;
        trap      = 1'b0;
        if (!rst) begin
            if ((r_state == EXEC) || (r_state == MEM) || (r_state == WB)) begin
                alu_ctrl  = w_dec.alu_ctrl;
                alu_src_a = w_dec.alu_src_a;
                alu_src_b = w_dec.alu_src_b;
                wb_sel    = w_dec.wb_sel;
                whb       = w_dec.whb;
                su        = w_dec.su;
            end
            case (r_state)
                FETCH: begin
                    imem_req = 1'b1;
                    ir_we    = imem_ack;
                end
                EXEC: begin
                    if (w_dec.iclass == CL_BRANCH) begin
                        pc_we  = 1'b1;
                        pc_src = br_cond ? PCSRC_BR : PCSRC_PC4;
                    end
                end
                MEM: begin
                    dmem_req = 1'b1;
                    dmem_we  = w_dec.dmem_we;
                    pc_we    = w_is_store && dmem_ack;
                end
                WB: begin
                    reg_write = 1'b1;
                    pc_we     = 1'b1;
                    if (w_dec.iclass == CL_JAL) begin
                        pc_src = PCSRC_BR;
                    end else if (w_dec.iclass == CL_JALR) begin
                        pc_src = PCSRC_JALR;
                    end
                end
                TRAP:    trap = 1'b1;
                default: ;
            endcase
        end
    end

    assign retired = r_retired;

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed table-driven bench for mc_control_unit plus hand sequences for trap, timeout and reset corners.
module tb_mc_control_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        imem_ack, dmem_ack, br_cond;
    logic        imem_req, dmem_req, dmem_we, ir_we, pc_we, reg_write;
    logic [1:0]  pc_src, wb_sel, whb;
    logic [3:0]  alu_ctrl;
    logic        alu_src_a, alu_src_b, su, trap;
    logic [3:0]  retired;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [3:0]  exp_ret  = '0;

    typedef struct {
        logic [31:0] instr;
        int          dly;
        logic        br;
        int          cyc;
        logic [3:0]  alu;
        logic        srca;
        logic        srcb;
        logic [1:0]  wbsel;
        logic [1:0]  whb;
        logic        su;
        logic        dwe;
        logic [1:0]  pcs;
        int          rw;
        logic        mem;
    } vec_t;

    vec_t tbl[15];

    mc_control_unit #(.XLEN(32), .TIMEOUT(4), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .instr(instr), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
        .br_cond(br_cond), .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .reg_write(reg_write),
        .alu_ctrl(alu_ctrl), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .wb_sel(wb_sel), .whb(whb), .su(su), .trap(trap), .retired(retired)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0; br_cond = 1'b0;
        repeat (n) @(posedge clk);
        #1 rst = 1'b0;
        exp_ret = '0;
    endtask

    task automatic run_vec(input int id, input vec_t v);
        int cyc = 0, mcyc = 0, rw_n = 0, excl = 0;
        logic done = 1'b0;
        logic [3:0] alu_s = '0;
        logic a_s = 1'b0, b_s = 1'b0, su_s = 1'b0, dwe_s = 1'b0;
        logic [1:0] whb_s = '0, wb_s = '0, pcs_s = 2'b11;
        instr = v.instr;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
            br_cond  = v.br;
            imem_ack = imem_req;
            dmem_ack = dmem_req && (mcyc == v.dly);
            #1;
            if (dmem_req) begin mcyc++; dwe_s = dmem_we; end
            if (cyc == 3) begin
                alu_s = alu_ctrl; a_s = alu_src_a; b_s = alu_src_b; whb_s = whb; su_s = su;
            end
            if (reg_write) begin rw_n++; wb_s = wb_sel; end
            if ((ir_we && pc_we) || (reg_write && dmem_req)) excl++;
            if (pc_we) begin pcs_s = pc_src; done = 1'b1; end
        end
        @(posedge clk); #1;
        imem_ack = 1'b0; dmem_ack = 1'b0; br_cond = 1'b0;
        exp_ret = exp_ret + 4'd1;
        check($sformatf("v%0d.cycles", id), cyc, v.cyc);
        check($sformatf("v%0d.alu_ctrl", id), alu_s, v.alu);
        check($sformatf("v%0d.alu_src_a", id), a_s, v.srca);
        check($sformatf("v%0d.alu_src_b", id), b_s, v.srcb);
        check($sformatf("v%0d.whb", id), whb_s, v.whb);
        check($sformatf("v%0d.su", id), su_s, v.su);
        check($sformatf("v%0d.pc_src", id), pcs_s, v.pcs);
        check($sformatf("v%0d.reg_write_cycles", id), rw_n, v.rw);
        check($sformatf("v%0d.dmem_req_cycles", id), mcyc, v.mem ? v.dly + 1 : 0);
        check($sformatf("v%0d.exclusive", id), excl, 0);
        check($sformatf("v%0d.retired", id), retired, exp_ret);
        if (v.rw != 0) check($sformatf("v%0d.wb_sel", id), wb_s, v.wbsel);
        if (v.mem) check($sformatf("v%0d.dmem_we", id), dwe_s, v.dwe);
    endtask

    task automatic run_illegal(input logic [31:0] ins);
        int trap_at = 0, pcwe_n = 0;
        logic [3:0] ret0;
        ret0 = retired;
        instr = ins;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            imem_ack = imem_req;
            #1;
            if (trap && trap_at == 0) trap_at = c;
            if (pc_we) pcwe_n++;
        end
        check($sformatf("illegal_%h.trap_cycle", ins), trap_at, 3);
        check($sformatf("illegal_%h.trap_held", ins), trap, 1);
        check($sformatf("illegal_%h.pc_we", ins), pcwe_n, 0);
        check($sformatf("illegal_%h.imem_req", ins), imem_req, 0);
        check($sformatf("illegal_%h.retired", ins), retired, ret0);
        do_reset(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int req_n, trap_at, pcwe_n;
        //            instr         dly br cyc alu     a  b  wb     whb    su dwe pcs   rw mem
        tbl[0]  = '{32'h00500093, 0, 0, 4, 4'b0000, 0, 1, 2'b01, 2'b10, 1, 0, 2'b00, 1, 0}; // ADDI
        tbl[1]  = '{32'h0000A103, 3, 0, 8, 4'b0000, 0, 1, 2'b10, 2'b10, 1, 0, 2'b00, 1, 1}; // LW late ack
        tbl[2]  = '{32'h00208463, 0, 1, 3, 4'b0001, 0, 0, 2'b01, 2'b10, 1, 0, 2'b01, 0, 0}; // BEQ taken
        tbl[3]  = '{32'h00208463, 0, 0, 3, 4'b0001, 0, 0, 2'b01, 2'b10, 1, 0, 2'b00, 0, 0}; // BEQ not taken
        tbl[4]  = '{32'h0020A023, 0, 0, 4, 4'b0000, 0, 1, 2'b01, 2'b10, 1, 1, 2'b00, 0, 1}; // SW
        tbl[5]  = '{32'h402081B3, 0, 0, 4, 4'b0001, 0, 0, 2'b01, 2'b10, 1, 0, 2'b00, 1, 0}; // SUB
        tbl[6]  = '{32'h4020D1B3, 0, 0, 4, 4'b1100, 0, 0, 2'b01, 2'b10, 1, 0, 2'b00, 1, 0}; // SRA
        tbl[7]  = '{32'h0020B1B3, 0, 0, 4, 4'b0001, 0, 0, 2'b00, 2'b10, 0, 0, 2'b00, 1, 0}; // SLTU
        tbl[8]  = '{32'h123452B7, 0, 0, 4, 4'b1101, 0, 1, 2'b01, 2'b10, 1, 0, 2'b00, 1, 0}; // LUI
        tbl[9]  = '{32'h008000EF, 0, 0, 4, 4'b0000, 1, 1, 2'b11, 2'b10, 1, 0, 2'b01, 1, 0}; // JAL
        tbl[10] = '{32'h00008067, 0, 0, 4, 4'b0000, 0, 1, 2'b11, 2'b10, 1, 0, 2'b10, 1, 0}; // JALR
        tbl[11] = '{32'h0000C103, 1, 0, 6, 4'b0000, 0, 1, 2'b10, 2'b00, 0, 0, 2'b00, 1, 1}; // LBU
        tbl[12] = '{32'h0020E463, 0, 1, 3, 4'b0001, 0, 0, 2'b01, 2'b10, 0, 0, 2'b01, 0, 0}; // BLTU taken
        tbl[13] = '{32'h00001097, 0, 0, 4, 4'b0000, 1, 1, 2'b01, 2'b10, 1, 0, 2'b00, 1, 0}; // AUIPC
        tbl[14] = '{32'h0FF0C093, 0, 0, 4, 4'b1000, 0, 1, 2'b01, 2'b10, 1, 0, 2'b00, 1, 0}; // XORI

        instr = '0;
        rst = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0; br_cond = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        check("reset.imem_req", imem_req, 0);
        check("reset.dmem_req", dmem_req, 0);
        check("reset.pc_we", pc_we, 0);
        check("reset.whb", whb, 2'b10);
        check("reset.su", su, 1);
        check("reset.trap", trap, 0);
        check("reset.retired", retired, 0);
        do_reset(1);

        for (int i = 0; i < 15; i++) run_vec(i, tbl[i]);
        run_vec(15, tbl[0]);  // 16th retire wraps the 4-bit counter to 0

        run_illegal(32'hFFFFFFFF);
        run_illegal(32'h00000073);
        run_illegal(32'h402091B3);

        // imem never acks: four request cycles then trap
        req_n = 0; trap_at = 0;
        for (int c = 1; c <= 20 && trap_at == 0; c++) begin
            @(negedge clk); #1;
            if (trap) trap_at = c;
            else if (imem_req) req_n++;
        end
        check("to_imem.req_cycles", req_n, 4);
        check("to_imem.trap_cycle", trap_at, 5);
        check("to_imem.req_dropped", imem_req, 0);
        do_reset(1);

        // dmem never acks on a store
        req_n = 0; trap_at = 0; pcwe_n = 0; instr = 32'h0020A023;
        for (int c = 1; c <= 20 && trap_at == 0; c++) begin
            @(negedge clk);
            imem_ack = imem_req;
            #1;
            if (trap) trap_at = c;
            else if (dmem_req) req_n++;
            if (pc_we) pcwe_n++;
        end
        check("to_dmem.req_cycles", req_n, 4);
        check("to_dmem.trap_cycle", trap_at, 8);
        check("to_dmem.pc_we", pcwe_n, 0);
        check("to_dmem.retired", retired, 0);
        do_reset(1);

        // reset pulse in the middle of a store's MEM phase
        run_vec(16, tbl[0]);
        instr = 32'h0020A023;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            imem_ack = imem_req;
            dmem_ack = 1'b0;
            #1;
            if (c == 4) check("mid_mem.dmem_req", dmem_req, 1);
        end
        @(posedge clk); #1;
        rst = 1'b1; imem_ack = 1'b0;
        @(negedge clk); dmem_ack = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk); #1;
        check("post_rst.imem_req", imem_req, 1);
        check("post_rst.dmem_req", dmem_req, 0);
        check("post_rst.retired", retired, 0);
        check("post_rst.trap", trap, 0);
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        @(negedge clk); #1;
        check("late_ack.imem_req", imem_req, 1);
        check("late_ack.reg_write", reg_write, 0);
        check("late_ack.retired", retired, 0);
        @(posedge clk); #1;
        exp_ret = '0;
        run_vec(17, tbl[0]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
